// File: rtl/vme_buffer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vme_buffer_sequencer
// Description : Sequences the direction and enable controls of the external
//               VME data and address/LWORD transceivers. A turnaround gap is
//               held around every direction change. Drive permission is
//               granted to the core only after the buffers face the bus. The
//               DTACK open-collector driver is pulled actively high before
//               its enable is released.
// Revision    : 1.0 - initial release
// ============================================================================
module vme_buffer_sequencer #(
  // Cycles the buffer enables stay off around a direction change (2..15)
  parameter int unsigned g_TURNAROUND = 2,
  // Cycles DTACK is driven high before its enable is dropped (1..7)
  parameter int unsigned g_DTACK_HOLD = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vme_as_n_i,
  input  logic drive_req_i,
  input  logic drive_mblt_i,
  input  logic dtack_req_i,
  output logic drive_gnt_o,
  output logic vme_data_dir_o,
  output logic vme_data_oe_n_o,
  output logic vme_addr_dir_o,
  output logic vme_addr_oe_n_o,
  output logic vme_dtack_oe_o,
  output logic vme_dtack_n_o,
  output logic busy_o
);

  localparam logic [3:0] c_TURNAROUND = 4'(g_TURNAROUND);
  localparam logic [2:0] c_DTACK_HOLD = 3'(g_DTACK_HOLD);

  typedef enum logic [2:0] {
    ST_PWRUP         = 3'd0,
    ST_LISTEN        = 3'd1,
    ST_OFF_TO_DRIVE  = 3'd2,
    ST_DRIVE         = 3'd3,
    ST_OFF_TO_LISTEN = 3'd4
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_mblt;
  logic       r_drive_gnt;
  logic       r_data_dir;
  logic       r_data_oe_n;
  logic       r_addr_dir;
  logic       r_addr_oe_n;
  logic       r_busy;

  logic       r_dtack_oe;
  logic       r_dtack_n;
  logic [2:0] r_hold_cnt;

  logic       w_cycle_lost;
  logic       w_dtack_ok;

  // The read cycle ends (or is abandoned) when the core withdraws its
  // request or the master releases the address strobe.
  assign w_cycle_lost = ~drive_req_i | vme_as_n_i;

  // DTACK may be asserted while the strobe is low, but never ahead of the
  // data: if the core is waiting for a grant, acknowledge waits with it.
  assign w_dtack_ok = dtack_req_i & ~vme_as_n_i & ~(drive_req_i & ~r_drive_gnt);

  // Buffer sequencing FSM; every output is registered alongside the state.
  // The counter holds the 1-based index of the current turnaround cycle
  // (0-based during PWRUP), so each gap state lasts g_TURNAROUND cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_PWRUP;
      r_cnt       <= 4'd0;
      r_mblt      <= 1'b0;
      r_drive_gnt <= 1'b0;
      r_data_dir  <= 1'b0;
      r_data_oe_n <= 1'b1;
      r_addr_dir  <= 1'b0;
      r_addr_oe_n <= 1'b1;
      r_busy      <= 1'b1;
    end else begin
      case (r_state)
        ST_PWRUP: begin
          if (r_cnt == c_TURNAROUND - 4'd1) begin
            r_state     <= ST_LISTEN;
            r_cnt       <= 4'd0;
            r_data_oe_n <= 1'b0;
            r_addr_oe_n <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        ST_LISTEN: begin
          if (drive_req_i && !vme_as_n_i) begin
            // First turnaround cycle: switch enables off, direction untouched.
            r_state     <= ST_OFF_TO_DRIVE;
            r_cnt       <= 4'd1;
            r_mblt      <= drive_mblt_i;
            r_busy      <= 1'b1;
            r_data_oe_n <= 1'b1;
            r_addr_oe_n <= drive_mblt_i;
          end
        end

        ST_OFF_TO_DRIVE: begin
          if (w_cycle_lost) begin
            // Abandoned before grant: keep current direction for the first
            // cycle of the return path so no pointless toggle is produced.
            r_state <= ST_OFF_TO_LISTEN;
            r_cnt   <= 4'd1;
          end else if (r_cnt == c_TURNAROUND) begin
            // Direction has been stable for at least one cycle: enable.
            r_state     <= ST_DRIVE;
            r_cnt       <= 4'd0;
            r_drive_gnt <= 1'b1;
            r_data_oe_n <= 1'b0;
            r_addr_oe_n <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + 4'd1;
            r_data_dir <= 1'b1;
            r_addr_dir <= r_mblt;
          end
        end

        ST_DRIVE: begin
          if (w_cycle_lost) begin
            // Grant and enables go away first; direction flips next cycle.
            r_state     <= ST_OFF_TO_LISTEN;
            r_cnt       <= 4'd1;
            r_drive_gnt <= 1'b0;
            r_data_oe_n <= 1'b1;
            r_addr_oe_n <= r_mblt;
          end
        end

        ST_OFF_TO_LISTEN: begin
          // Requests are not looked at here; LISTEN re-evaluates them.
          if (r_cnt == c_TURNAROUND) begin
            r_state     <= ST_LISTEN;
            r_cnt       <= 4'd0;
            r_busy      <= 1'b0;
            r_data_dir  <= 1'b0;
            r_data_oe_n <= 1'b0;
            r_addr_dir  <= 1'b0;
            r_addr_oe_n <= 1'b0;
          end else begin
            r_cnt      <= r_cnt + 4'd1;
            r_data_dir <= 1'b0;
            r_addr_dir <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_PWRUP;
          r_cnt       <= 4'd0;
          r_mblt      <= 1'b0;
          r_drive_gnt <= 1'b0;
          r_data_dir  <= 1'b0;
          r_data_oe_n <= 1'b1;
          r_addr_dir  <= 1'b0;
          r_addr_oe_n <= 1'b1;
          r_busy      <= 1'b1;
        end
      endcase
    end
  end

  // DTACK driver: assert low, then drive high for g_DTACK_HOLD cycles
  // before tri-stating so the line is not left to the slow pull-up.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dtack_oe <= 1'b0;
      r_dtack_n  <= 1'b1;
      r_hold_cnt <= 3'd0;
    end else if (w_dtack_ok) begin
      r_dtack_oe <= 1'b1;
      r_dtack_n  <= 1'b0;
      r_hold_cnt <= 3'd0;
    end else if (r_dtack_oe && !r_dtack_n) begin
      r_dtack_n  <= 1'b1;
      r_hold_cnt <= 3'd1;
    end else if (r_dtack_oe) begin
      if (r_hold_cnt == c_DTACK_HOLD) begin
        r_dtack_oe <= 1'b0;
      end else begin
        r_hold_cnt <= r_hold_cnt + 3'd1;
      end
    end
  end

  assign drive_gnt_o     = r_drive_gnt;
  assign vme_data_dir_o  = r_data_dir;
  assign vme_data_oe_n_o = r_data_oe_n;
  assign vme_addr_dir_o  = r_addr_dir;
  assign vme_addr_oe_n_o = r_addr_oe_n;
  assign vme_dtack_oe_o  = r_dtack_oe;
  assign vme_dtack_n_o   = r_dtack_n;
  assign busy_o          = r_busy;

endmodule
`default_nettype wire
